truth_table_sequencer: RTL and testbench

//   Synthesizable exhaustive-stimulus controller for a small combinational circuit under test (CUT).
//   On start, it walks every input vector 0..2^N_IN-1 on dut_in and waits SETTLE_CYC cycles per vector.
//   It samples dut_out and compares it with the expected truth table EXP_TT, then reports pass/fail,

---
 rtl/ttseq_pkg.sv | 16 +
 rtl/ttseq_settle_cnt.sv | 31 +++
 rtl/truth_table_sequencer.sv | 111 +++++++++++
 tb/tb_truth_table_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttseq_pkg.sv
// Shared types and sizing helpers for the truth-table sequencer.
package ttseq_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} ttseq_state_t;

    // Number of input vectors for an n_in-bit circuit under test.
    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

    // The counter must be at least one bit wide, even when there is only one settle cycle.
    function automatic int cnt_width(input int settle_cyc);
        return (settle_cyc > 1) ? $clog2(settle_cyc) : 1;
    endfunction

endpackage

// File: rtl/ttseq_settle_cnt.sv
// Settle-cycle counter: load clears it, en advances it, and expire marks the last settle cycle.
module ttseq_settle_cnt
    import ttseq_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = cnt_width(SETTLE_CYC);

    logic [CW-1:0] cnt;

    assign expire = (cnt == CW'(SETTLE_CYC - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || (en && expire)) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive-stimulus controller: walks every vector, compares the CUT output with EXP_TT and reports results.
// Optional feature: define TTSEQ_CAPTURE_EN to add the obs_tt observed-truth-table output.
module truth_table_sequencer
    import ttseq_pkg::*;
#(
    parameter int                          N_IN       = 3,
    parameter int                          SETTLE_CYC = 4,
    parameter logic [vec_count(N_IN)-1:0] EXP_TT     = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_vld
`ifdef TTSEQ_CAPTURE_EN
   ,output logic [vec_count(N_IN)-1:0] obs_tt
`endif
);

    localparam int VEC = vec_count(N_IN);

    ttseq_state_t state;
    logic         accept;
    logic         expire;
    logic         mismatch;
    logic         last_vec;

    // dut_in is the vector index register itself, so it always equals idx.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign mismatch = (dut_out != EXP_TT[dut_in]);
    assign last_vec = (dut_in == N_IN'(VEC - 1));

    ttseq_settle_cnt #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .en     (state == SETTLE),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
`ifdef TTSEQ_CAPTURE_EN
            obs_tt         <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state          <= SETTLE;
                        dut_in         <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        first_fail_vld <= 1'b0;
`ifdef TTSEQ_CAPTURE_EN
                        obs_tt         <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + (N_IN + 1)'(1);
                        if (!first_fail_vld) begin
                            first_fail_vec <= dut_in;
                            first_fail_vld <= 1'b1;
                        end
                    end
`ifdef TTSEQ_CAPTURE_EN
                    obs_tt[dut_in] <= dut_out;
`endif
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // pass reflects the final tally including this last comparison.
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        state  <= SETTLE;
                        dut_in <= dut_in + N_IN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer with a behavioural CUT and a result scoreboard.
// Define TTSEQ_CAPTURE_EN to also check the obs_tt output.
module tb_truth_table_sequencer;

    localparam logic [7:0] EXP = 8'b1110_1000;

    typedef struct packed {
        logic       pass;
        logic [3:0] err;
        logic       ffv;
        logic [2:0] ffvec;
        logic [7:0] obs;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [2:0] dut_in0, dut_in1;
    logic       cut0, cut1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] err0, err1;
    logic [2:0] ffvec0, ffvec1;
    logic       ffv0, ffv1;
    logic [7:0] obs0, obs1;
    int         mode = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    // mode 0: majority, mode 1: majority with vector 5 inverted, mode 2: stuck-at-0
    function automatic logic cut_fn(input logic [2:0] v, input int m);
        logic maj;
        maj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
        case (m)
            1:       return maj ^ (v == 3'd5);
            2:       return 1'b0;
            default: return maj;
        endcase
    endfunction

    assign cut0 = cut_fn(dut_in0, mode);
    assign cut1 = cut_fn(dut_in1, mode);

    truth_table_sequencer #(.N_IN(3), .SETTLE_CYC(4), .EXP_TT(EXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_in(dut_in0), .dut_out(cut0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffvec0), .first_fail_vld(ffv0)
`ifdef TTSEQ_CAPTURE_EN
       ,.obs_tt(obs0)
`endif
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE_CYC(1), .EXP_TT(EXP)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(dut_in1), .dut_out(cut1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffvec1), .first_fail_vld(ffv1)
`ifdef TTSEQ_CAPTURE_EN
       ,.obs_tt(obs1)
`endif
    );

`ifndef TTSEQ_CAPTURE_EN
    assign obs0 = '0;
    assign obs1 = '0;
`endif

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input int m, input int lat);
        exp_t e;
        logic o;
        e = '0;
        for (int v = 0; v < 8; v++) begin
            o = cut_fn(3'(v), m);
            e.obs[v] = o;
            if (o !== EXP[v]) begin
                if (!e.ffv) begin
                    e.ffv   = 1'b1;
                    e.ffvec = 3'(v);
                end
                e.err = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 4'd0);
        e.lat  = lat;
        return e;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy0), 0);
        check({tag, "_done"}, 32'(done0), 0);
        check({tag, "_pass"}, 32'(pass0), 0);
        check({tag, "_err"},  32'(err0), 0);
        check({tag, "_ffv"},  32'(ffv0), 0);
        check({tag, "_ffvec"}, 32'(ffvec0), 0);
        check({tag, "_dutin"}, 32'(dut_in0), 0);
`ifdef TTSEQ_CAPTURE_EN
        check({tag, "_obs"}, 32'(obs0), 0);
`endif
    endtask

    // Pushes the expected result, then drives start across one accepting edge.
    task automatic kick(input int sel, input int m, input bit hold);
        mode = m;
        sb.push_back(model(m, (sel == 0) ? 40 : 16));
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start0 = 1'b0;
            start1 = 1'b0;
        end
        check($sformatf("busy_after_start%0d", sel), 32'(sel == 0 ? busy0 : busy1), 1);
    endtask

    task automatic wait_done(input int sel, input string tag, input int pulse_at);
        int   cyc;
        logic seen;
        exp_t e;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 200 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = (sel == 0) ? done0 : done1;
            if (cyc == pulse_at) start0 = 1'b1;
            else if (cyc == pulse_at + 1) start0 = 1'b0;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
            if (sel == 0) begin
                check({tag, "_pass"},  32'(pass0), 32'(e.pass));
                check({tag, "_err"},   32'(err0), 32'(e.err));
                check({tag, "_ffv"},   32'(ffv0), 32'(e.ffv));
                if (e.ffv) check({tag, "_ffvec"}, 32'(ffvec0), 32'(e.ffvec));
                check({tag, "_dutin_last"}, 32'(dut_in0), 7);
                check({tag, "_busy"},  32'(busy0), 0);
`ifdef TTSEQ_CAPTURE_EN
                check({tag, "_obs"},   32'(obs0), 32'(e.obs));
`endif
            end else begin
                check({tag, "_pass"},  32'(pass1), 32'(e.pass));
                check({tag, "_err"},   32'(err1), 32'(e.err));
                check({tag, "_ffv"},   32'(ffv1), 32'(e.ffv));
                if (e.ffv) check({tag, "_ffvec"}, 32'(ffvec1), 32'(e.ffvec));
                check({tag, "_dutin_last"}, 32'(dut_in1), 7);
`ifdef TTSEQ_CAPTURE_EN
                check({tag, "_obs"},   32'(obs1), 32'(e.obs));
`endif
            end
        end
    endtask

    initial begin
        // Reset state, both while held and after release.
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_held");
        check("reset_done1", 32'(done1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_released");

        // Majority CUT, all vectors correct.
        kick(0, 0, 1'b0);
        wait_done(0, "maj_ok", -10);
        check("maj_ok_hold_done", 32'(done0), 1);

        // Vector 5 inverted: one error, first fail 5.
        kick(0, 1, 1'b0);
        wait_done(0, "inv5", -10);

        // Stuck-at-0: errors on 3,5,6,7.
        kick(0, 2, 1'b0);
        wait_done(0, "stuck0", -10);

        // start pulsed during vector 2 is ignored.
        kick(0, 0, 1'b0);
        wait_done(0, "start_busy", 12);

        // start held high: runs, then restarts immediately from DONE.
        kick(0, 1, 1'b1);
        wait_done(0, "hold_first", -10);
        mode = 0;
        sb.push_back(model(0, 40));
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check("hold_restart_busy", 32'(busy0), 1);
        check("hold_restart_done", 32'(done0), 0);
        check("hold_restart_err", 32'(err0), 0);
        wait_done(0, "hold_second", -10);

        // Reset during vector 4 aborts; a fresh run then completes.
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (22) begin
            @(posedge clk);
            #1;
        end
        check("abort_at_vec4", 32'(dut_in0), 4);
        rst_n = 1'b0;
        #1;
        check_idle("abort_async");
        @(posedge clk);
        #1;
        check_idle("abort_held");
        rst_n = 1'b1;
        kick(0, 0, 1'b0);
        wait_done(0, "after_abort", -10);

        // Single settle cycle instance: 16-cycle run with vector 5 inverted.
        kick(1, 1, 1'b0);
        wait_done(1, "settle1", -10);

        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
